// File: rtl/key_schedule_pkg.sv
// Shared cipher constants for the PRESENT-80 style datapath and its key schedule.
package key_schedule_pkg;
   localparam int KEY_W     = 80;
   localparam int STATE_W   = 64;
   localparam int ROUNDS    = 31;
   localparam int FINAL_IDX = 32;
   localparam int ROT_AMT   = 61;
   localparam int CNT_HI    = 19;
   localparam int CNT_LO    = 15;
   localparam int RC_W      = 6;

   typedef logic [KEY_W-1:0] key_t;
   typedef logic [RC_W-1:0]  rc_t;

   localparam rc_t RC_FIRST = rc_t'(1);
   localparam rc_t RC_FINAL = rc_t'(FINAL_IDX);
endpackage

// File: rtl/key_schedule_sbox.sv
// PRESENT 4-bit S-box, shared by the substitution layer and the key schedule.
module key_schedule_sbox (
   input  logic [3:0] a,
   output logic [3:0] y
);
   always_comb begin
      y = 4'h0;
      case (a)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
   end
endmodule

// File: rtl/key_schedule.sv
// Round-key generator: one 80-bit key register plus rc/valid/last control, one key per advance.
module key_schedule
   import key_schedule_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [KEY_W-1:0] key_in,
   input  logic             next,
   output logic [KEY_W-1:0] k,
   output logic [RC_W-1:0]  rc,
   output logic             valid,
   output logic             last
);
   key_t       rot;
   key_t       k_nxt;
   logic [3:0] sb_out;
   logic       advance;

   assign rot     = {k[KEY_W-1-ROT_AMT:0], k[KEY_W-1:KEY_W-ROT_AMT]};
   assign advance = next & valid & ~last;

   key_schedule_sbox u_sbox (
      .a (rot[KEY_W-1:KEY_W-4]),
      .y (sb_out)
   );

   // rc is mixed in before it increments
   always_comb begin
      k_nxt = {sb_out, rot[KEY_W-5:0]};
      k_nxt[CNT_HI:CNT_LO] = k_nxt[CNT_HI:CNT_LO] ^ rc[CNT_HI-CNT_LO:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k <= '0;
      end else if (load) begin
         k <= key_in;
      end else if (advance) begin
         k <= k_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rc    <= '0;
         valid <= 1'b0;
         last  <= 1'b0;
      end else if (load) begin
         rc    <= RC_FIRST;
         valid <= 1'b1;
         last  <= 1'b0;
      end else if (advance) begin
         rc    <= rc + RC_FIRST;
         last  <= (rc == RC_FINAL - RC_FIRST);
      end
   end
endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: behavioural schedule model checked every cycle, plus directed scenarios.
module tb_key_schedule;
   logic        clk = 1'b0;
   logic        rst_n, load, next;
   logic [79:0] key_in;
   logic [79:0] k;
   logic [5:0]  rc;
   logic        valid, last;

   int n_chk  = 0;
   int n_fail = 0;

   key_schedule dut (
      .clk(clk), .rst_n(rst_n), .load(load), .key_in(key_in), .next(next),
      .k(k), .rc(rc), .valid(valid), .last(last)
   );

   always #5 clk = ~clk;

   logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   function automatic logic [79:0] ks_step(logic [79:0] kk, logic [5:0] r);
      logic [79:0] t;
      t = (kk << 61) | (kk >> 19);
      t[79:76] = SB[t[79:76]];
      t[19:15] = t[19:15] ^ r[4:0];
      return t;
   endfunction

   function automatic logic [63:0] present_round(logic [63:0] s, logic [63:0] rk);
      logic [63:0] x, p;
      x = s ^ rk;
      for (int n = 0; n < 16; n++) x[4*n +: 4] = SB[x[4*n +: 4]];
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16 * i) % 63] = x[i];
      return p;
   endfunction

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Behavioural model of the schedule, advanced on each rising edge
   logic [79:0] m_k;
   int          m_rc;
   bit          m_init = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_k = '0; m_rc = 0; m_init = 1'b1;
      end else if (load) begin
         m_k = key_in; m_rc = 1;
      end else if (next && m_rc >= 1 && m_rc < 32) begin
         m_k = ks_step(m_k, 6'(m_rc));
         m_rc++;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("model_k", k, m_k);
         chk("model_rc", 80'(rc), 80'(m_rc));
         chk("model_valid", 80'(valid), 80'(m_rc != 0));
         chk("model_last", 80'(last), 80'(m_rc == 32));
      end
   end

   task automatic step(input logic r, input logic ld, input logic [79:0] kin, input logic nx);
      rst_n = r; load = ld; key_in = kin; next = nx;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [79:0] mk, hold_k;
      logic [63:0] st;
      int n;

      // model self-pins
      chk("pin_step1", ks_step(80'h0, 6'd1), 80'hC0000000000000008000);
      mk = '0; st = '0;
      for (int r = 1; r <= 31; r++) begin
         st = present_round(st, mk[79:16]);
         mk = ks_step(mk, 6'(r));
      end
      chk("pin_cipher", 80'(st ^ mk[79:16]), 80'h5579C1387B228445);

      // reset overrides load
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '1, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0);
      chk("rst_k", k, 80'h0);
      chk("rst_ctl", 80'({rc, valid, last}), 80'h0);

      // idle next ignored
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("idle_k", k, 80'h0);
      chk("idle_ctl", 80'({rc, valid, last}), 80'h0);

      // load zero then full run
      step(1'b1, 1'b1, '0, 1'b0);
      chk("load_k", k, 80'h0);
      chk("load_ctl", 80'({rc, valid, last}), 80'({6'd1, 1'b1, 1'b0}));
      st = '0;
      for (int r = 1; r <= 31; r++) begin
         st = present_round(st, k[79:16]);
         step(1'b1, 1'b0, '0, 1'b1);
         if (r == 1) begin
            chk("adv1_k", k, 80'hC0000000000000008000);
            chk("adv1_rc", 80'(rc), 80'd2);
         end
         if (r == 30) chk("rc31_last", 80'({rc, last}), 80'({6'd31, 1'b0}));
      end
      chk("final_ctl", 80'({rc, valid, last}), 80'({6'd32, 1'b1, 1'b1}));
      chk("cipher", 80'(st ^ k[79:16]), 80'h5579C1387B228445);
      hold_k = k;
      step(1'b1, 1'b0, '0, 1'b1);
      chk("hold32_k", k, hold_k);
      chk("hold32_rc", 80'({rc, last}), 80'({6'd32, 1'b1}));

      // load/next priority at rc=5
      step(1'b1, 1'b1, '0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);
      chk("pre_prio_rc", 80'(rc), 80'd5);
      step(1'b1, 1'b1, '1, 1'b1);
      chk("prio_k", k, {80{1'b1}});
      chk("prio_ctl", 80'({rc, valid, last}), 80'({6'd1, 1'b1, 1'b0}));

      // reset mid-run at rc=17
      step(1'b1, 1'b1, {$urandom, $urandom, 16'($urandom)}, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, 1'b1);
      chk("pre_rst_rc", 80'(rc), 80'd17);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("midrst_k", k, 80'h0);
      chk("midrst_ctl", 80'({rc, valid, last}), 80'h0);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("midrst_next_ctl", 80'({rc, valid}), 80'h0);

      // randomized traffic against the model
      n = 0;
      repeat (1500) begin
         step(($urandom_range(0, 60) != 0), ($urandom_range(0, 20) == 0),
              {$urandom, $urandom, 16'($urandom)}, ($urandom_range(0, 3) != 0));
         n++;
      end
      step(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
